// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus between the fetch sequencer and the fetch block: redirect
// strobes/targets and PC+1 in, next PC, PC enable and IF/ID flush out.
interface fetch_sequencer_if #(
   parameter int width_B = 32
);
   logic               branch_taken;
   logic [width_B-1:0] branch_target;
   logic               jump;
   logic [width_B-1:0] jump_target;
   logic [width_B-1:0] PC_sumado;
   logic [width_B-1:0] PC_next;
   logic               PC_write;
   logic               flush_IFID;

   modport master (
      input  branch_taken, branch_target, jump, jump_target, PC_sumado,
      output PC_next, PC_write, flush_IFID
   );

   modport slave (
      output branch_taken, branch_target, jump, jump_target, PC_sumado,
      input  PC_next, PC_write, flush_IFID
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Debug-aware fetch sequencer: IDLE/RUN/HALT/STEP control of the PC enable,
// redirect selection, IF/ID flush, fetch counting and sticky bad-target trap.
module fetch_sequencer #(
   parameter int width_B = 32,
   parameter int Addr_B  = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               halt_req,
   input  logic               step_req,
   input  logic               stall,
   fetch_sequencer_if.master  bus,
   output logic               addr_error,
   output logic [1:0]         state,
   output logic [width_B-1:0] fetch_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2,
      STEP = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [width_B-1:0] fetch_count_r;
   logic               addr_error_r;

   logic               redirect_s;
   logic [width_B-1:0] sel_target_s;
   logic [width_B-1:0] pc_next_s;
   logic               active_s;
   logic               bad_target_s;
   logic               pc_write_s;
   logic               flush_s;

   // A target is unreachable when any bit at or above the ROM address width is set.
   function automatic logic out_of_range(input logic [width_B-1:0] tgt);
      return ((tgt >> Addr_B) != {width_B{1'b0}});
   endfunction

   // Redirect selection and fetch enables; a redirect beats a stall, a bad target kills both.
   always_comb begin
      redirect_s = bus.branch_taken | bus.jump;
      if (bus.branch_taken) begin
         sel_target_s = bus.branch_target;
      end else begin
         sel_target_s = bus.jump_target;
      end
      if (redirect_s) begin
         pc_next_s = sel_target_s;
      end else begin
         pc_next_s = bus.PC_sumado;
      end
      active_s     = (state_r == RUN) || (state_r == STEP);
      bad_target_s = active_s & redirect_s & out_of_range(sel_target_s);
      pc_write_s   = active_s & ~bad_target_s & (~stall | redirect_s);
      flush_s      = pc_write_s & redirect_s;
   end

   // Next-state logic; halt wins over start in RUN, start wins over step in HALT.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (bad_target_s || halt_req) begin
               state_nxt_s = HALT;
            end else begin
               state_nxt_s = RUN;
            end
         end
         HALT: begin
            if (start && !addr_error_r) begin
               state_nxt_s = RUN;
            end else if (step_req) begin
               state_nxt_s = STEP;
            end else begin
               state_nxt_s = HALT;
            end
         end
         STEP: begin
            state_nxt_s = HALT;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Committed-fetch counter (wraps naturally) and sticky bad-target flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count_r <= {width_B{1'b0}};
         addr_error_r  <= 1'b0;
      end else begin
         if (pc_write_s) begin
            fetch_count_r <= fetch_count_r + {{(width_B-1){1'b0}}, 1'b1};
         end
         if (bad_target_s) begin
            addr_error_r <= 1'b1;
         end
      end
   end

   assign bus.PC_next    = pc_next_s;
   assign bus.PC_write   = pc_write_s;
   assign bus.flush_IFID = flush_s;
   assign state          = state_r;
   assign addr_error     = addr_error_r;
   assign fetch_count    = fetch_count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then random cycles,
// expectations from a rule-level reference model, checked by a separate monitor.
module tb_fetch_sequencer;

   localparam int W = 32;
   localparam int A = 10;

   logic         clk;
   logic         reset;
   logic         start;
   logic         halt_req;
   logic         step_req;
   logic         stall;
   logic         addr_error;
   logic [1:0]   state;
   logic [W-1:0] fetch_count;

   fetch_sequencer_if #(.width_B(W)) bus ();

   fetch_sequencer #(.width_B(W), .Addr_B(A)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .halt_req    (halt_req),
      .step_req    (step_req),
      .stall       (stall),
      .bus         (bus),
      .addr_error  (addr_error),
      .state       (state),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] pcn;
      logic         pw;
      logic         fl;
      logic         err;
      logic [1:0]   st;
      logic [W-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model: 0 idle, 1 run, 2 halted, 3 single-stepping
   int           m_mode;
   logic [W-1:0] m_cnt;
   logic         m_err;

   task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
      end
   endtask

   task automatic drive(input logic rs, input logic st, input logic hr, input logic sr,
                        input logic sl, input logic bt, input logic [W-1:0] btg,
                        input logic jp, input logic [W-1:0] jtg, input logic [W-1:0] ps);
      exp_t         e;
      logic [W-1:0] tgt;
      logic         redirect, active, bad, pw;
      int           nmode;
      @(negedge clk);
      reset = rs; start = st; halt_req = hr; step_req = sr; stall = sl;
      bus.branch_taken = bt; bus.branch_target = btg;
      bus.jump = jp; bus.jump_target = jtg; bus.PC_sumado = ps;

      redirect = bt || jp;
      tgt      = bt ? btg : jtg;
      active   = (m_mode == 1) || (m_mode == 3);
      bad      = active && redirect && (tgt >= (W'(1) << A));
      pw       = active && !bad && (!sl || redirect);
      e.pcn = redirect ? tgt : ps;
      e.pw  = pw;
      e.fl  = pw && redirect;
      e.err = m_err;
      e.st  = m_mode[1:0];
      e.cnt = m_cnt;
      q.push_back(e);

      if (m_mode == 0)      nmode = st ? 1 : 0;
      else if (m_mode == 1) nmode = (bad || hr) ? 2 : 1;
      else if (m_mode == 2) nmode = (st && !m_err) ? 1 : (sr ? 3 : 2);
      else                  nmode = 2;

      @(posedge clk);
      if (rs) begin
         m_mode = 0; m_cnt = '0; m_err = 1'b0;
      end else begin
         m_mode = nmode;
         m_cnt  = m_cnt + (pw ? 1 : 0);
         m_err  = m_err || bad;
      end
   endtask

   task automatic idle_cycles(input int n, input logic sl);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, sl, 0, '0, 0, '0, 32'd5);
   endtask

   task automatic rand_cycle();
      logic [W-1:0] btg, jtg;
      btg = ($urandom_range(0, 9) == 0) ? $urandom : W'($urandom_range(0, 1023));
      jtg = ($urandom_range(0, 9) == 0) ? $urandom : W'($urandom_range(0, 1023));
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, btg,
            $urandom_range(0, 5) == 0, jtg, $urandom);
   endtask

   // Monitor: pops one expectation per cycle once outputs have settled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("PC_next",     bus.PC_next,          e.pcn);
            chk("PC_write",    W'(bus.PC_write),     W'(e.pw));
            chk("flush_IFID",  W'(bus.flush_IFID),   W'(e.fl));
            chk("addr_error",  W'(addr_error),       W'(e.err));
            chk("state",       W'(state),            W'(e.st));
            chk("fetch_count", fetch_count,          e.cnt);
            cyc++;
         end
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; halt_req = 1'b0; step_req = 1'b0; stall = 1'b0;
      bus.branch_taken = 1'b0; bus.branch_target = '0;
      bus.jump = 1'b0; bus.jump_target = '0; bus.PC_sumado = '0;
      repeat (2) @(posedge clk);
      m_mode = 0; m_cnt = '0; m_err = 1'b0;

      // start, free run
      idle_cycles(1, 1'b0);
      drive(0, 1, 0, 0, 0, 0, '0, 0, '0, 32'd5);
      idle_cycles(3, 1'b0);
      // stall, then redirect through a stall
      idle_cycles(3, 1'b1);
      drive(0, 0, 0, 0, 1, 1, 32'h40, 0, '0, 32'd6);
      // branch beats jump
      drive(0, 0, 0, 0, 0, 1, 32'h10, 1, 32'h20, 32'd7);
      drive(0, 0, 0, 0, 0, 0, '0, 1, 32'h20, 32'd8);
      // halt with start together, dropped redirect while halted, single step
      drive(0, 1, 1, 0, 0, 0, '0, 0, '0, 32'd9);
      drive(0, 0, 0, 0, 0, 1, 32'h30, 1, 32'h31, 32'd9);
      drive(0, 0, 0, 1, 0, 0, '0, 0, '0, 32'd9);
      idle_cycles(2, 1'b0);
      // start and step together resolve to run
      drive(0, 1, 0, 1, 0, 0, '0, 0, '0, 32'd10);
      // out-of-range jump, later start ignored, reset clears
      drive(0, 0, 0, 0, 0, 0, '0, 1, 32'h400, 32'd11);
      idle_cycles(1, 1'b0);
      drive(0, 1, 0, 0, 0, 0, '0, 0, '0, 32'd12);
      idle_cycles(1, 1'b0);
      drive(0, 0, 0, 1, 0, 0, '0, 0, '0, 32'd12);
      drive(1, 0, 0, 0, 0, 1, 32'h999, 0, '0, 32'd12);
      idle_cycles(1, 1'b0);
      // reset mid-step
      drive(0, 1, 0, 0, 0, 0, '0, 0, '0, 32'd13);
      drive(0, 0, 1, 0, 0, 0, '0, 0, '0, 32'd13);
      drive(0, 0, 0, 1, 0, 0, '0, 0, '0, 32'd13);
      drive(1, 0, 0, 0, 0, 0, '0, 1, 32'h22, 32'd13);
      idle_cycles(2, 1'b0);

      for (int i = 0; i < 3000; i++) rand_cycle();

      @(negedge clk);
      #5;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain cycle=%0d got=%0d expected=0", cyc, q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
